// File: rtl/float_normalize_round_if.sv
// ---------------------------------------------------------------------------
// float_normalize_round_if
// Operand/result handshake bundle for the float adder packer stage.
//   in_valid/in_ready   : operand handshake (master drives valid + payload)
//   in_mant             : 28-bit signed working mantissa
//                         [27]=sign [26]=carry [25]=hidden [24:2]=frac
//                         [1]=guard [0]=sticky
//   in_exp              : biased exponent matching hidden bit at [25]
//   out_valid/out_ready : result handshake (slave drives valid + payload)
//   result              : packed IEEE-754 single
//   overflow/underflow/inexact : status flags accompanying result
// modport slave is the packer itself; modport master is the producer/consumer.
// ---------------------------------------------------------------------------
interface float_normalize_round_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    logic                    in_valid;
    logic                    in_ready;
    logic [FRAC_W+4:0]       in_mant;
    logic [EXP_W-1:0]        in_exp;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+FRAC_W:0]   result;
    logic                    overflow;
    logic                    underflow;
    logic                    inexact;

    modport master (
        output in_valid, in_mant, in_exp, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, inexact
    );

    modport slave (
        input  in_valid, in_mant, in_exp, out_ready,
        output in_ready, out_valid, result, overflow, underflow, inexact
    );
endinterface

// File: rtl/float_normalize_round.sv
// ---------------------------------------------------------------------------
// float_normalize_round
// Back-end packer of the float adder. Takes the signed working mantissa and
// biased exponent after add/sub, normalizes one bit per cycle, rounds to
// nearest-even and packs an IEEE-754 single. One operation in flight.
// Ports:
//   clk : rising-edge clock
//   res : asynchronous active-low reset
//   bus : float_normalize_round_if.slave (operand in, result + flags out)
// FSM: IDLE -> CHECK -> [NORM]* -> ROUND -> DONE -> IDLE
// ---------------------------------------------------------------------------
module float_normalize_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    res,
    float_normalize_round_if.slave  bus
);
    localparam int MAG_W = FRAC_W + 4;              // mantissa without sign
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_NORM  = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]             r_state;
    logic                   r_sign;
    logic [MAG_W-1:0]       r_mag;
    logic [EXP_W-1:0]       r_exp;
    logic [EXP_W+FRAC_W:0]  r_result;
    logic                   r_ovf;
    logic                   r_unf;
    logic                   r_inx;

    // ---- CHECK: carry-out renormalization (right shift keeps sticky) ----
    logic [MAG_W-1:0]       w_mag_shr;
    logic [EXP_W-1:0]       w_exp_inc;
    assign w_mag_shr = {1'b0, r_mag[MAG_W-1:2], r_mag[1] | r_mag[0]};
    assign w_exp_inc = r_exp + EXP_ONE;

    // ---- NORM: single-bit left shift ----
    logic [MAG_W-1:0]       w_mag_shl;
    logic [EXP_W-1:0]       w_exp_dec;
    logic                   w_can_shift;
    assign w_mag_shl   = {r_mag[MAG_W-2:0], 1'b0};
    assign w_exp_dec   = r_exp - EXP_ONE;
    assign w_can_shift = !r_mag[FRAC_W+2] && (r_exp > EXP_ONE);

    // ---- ROUND: nearest-even on mag[26:2] ----
    logic                   w_lsb;
    logic                   w_g;
    logic                   w_s;
    logic                   w_rnd_up;
    logic [FRAC_W+1:0]      w_inc;      // index i corresponds to mag[i+2]
    logic                   w_rcarry;
    logic                   w_hidden;
    logic [FRAC_W-1:0]      w_frac;
    logic [EXP_W-1:0]       w_rexp;
    logic                   w_rovf;
    logic [EXP_W-1:0]       w_field;

    assign w_lsb    = r_mag[2];
    assign w_g      = r_mag[1];
    assign w_s      = r_mag[0];
    assign w_rnd_up = w_g & (w_s | w_lsb);
    assign w_inc    = r_mag[MAG_W-1:2] + {{(FRAC_W+1){1'b0}}, w_rnd_up};
    // Rounding can only carry into [26] from an all-ones significand, so the
    // post-carry shift never loses a set bit.
    assign w_rcarry = w_inc[FRAC_W+1];
    assign w_hidden = w_rcarry | w_inc[FRAC_W];
    assign w_frac   = w_rcarry ? w_inc[FRAC_W:1] : w_inc[FRAC_W-1:0];
    assign w_rexp   = w_rcarry ? w_exp_inc : r_exp;
    assign w_rovf   = w_rcarry && (w_exp_inc == EXP_MAX);
    // A clear hidden bit after rounding means a denormal/zero encoding.
    assign w_field  = w_hidden ? w_rexp : '0;

    // ---- handshake outputs ----
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
    assign bus.inexact   = r_inx;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state  <= S_IDLE;
            r_sign   <= 1'b0;
            r_mag    <= '0;
            r_exp    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inx    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign <= bus.in_mant[FRAC_W+4];
                        r_mag  <= bus.in_mant[MAG_W-1:0];
                        // Exponent 0 shares the denormal scale of exponent 1.
                        r_exp  <= (bus.in_exp == '0) ? EXP_ONE : bus.in_exp;
                        if (bus.in_exp == EXP_MAX) begin
                            r_result <= {bus.in_mant[FRAC_W+4], EXP_MAX, {FRAC_W{1'b0}}};
                            r_ovf    <= 1'b1;
                            r_unf    <= 1'b0;
                            r_inx    <= 1'b0;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CHECK;
                        end
                    end
                end

                S_CHECK: begin
                    if (r_mag == '0) begin
                        r_result <= {r_sign, {(EXP_W+FRAC_W){1'b0}}};
                        r_ovf    <= 1'b0;
                        r_unf    <= 1'b0;
                        r_inx    <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (r_mag[MAG_W-1]) begin
                        r_mag <= w_mag_shr;
                        r_exp <= w_exp_inc;
                        if (w_exp_inc == EXP_MAX) begin
                            r_result <= {r_sign, EXP_MAX, {FRAC_W{1'b0}}};
                            r_ovf    <= 1'b1;
                            r_unf    <= 1'b0;
                            r_inx    <= 1'b0;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_ROUND;
                        end
                    end else if (r_mag[FRAC_W+2]) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_state <= S_NORM;
                    end
                end

                S_NORM: begin
                    // Exit decision looks at the shifted value so each left
                    // shift costs exactly one cycle.
                    if (w_can_shift) begin
                        r_mag <= w_mag_shl;
                        r_exp <= w_exp_dec;
                        if (w_mag_shl[FRAC_W+2] || (w_exp_dec == EXP_ONE))
                            r_state <= S_ROUND;
                    end else begin
                        r_state <= S_ROUND;
                    end
                end

                S_ROUND: begin
                    r_inx <= w_g | w_s;
                    if (w_rovf) begin
                        r_result <= {r_sign, EXP_MAX, {FRAC_W{1'b0}}};
                        r_ovf    <= 1'b1;
                        r_unf    <= 1'b0;
                    end else begin
                        r_result <= {r_sign, w_field, w_frac};
                        r_ovf    <= 1'b0;
                        // Zero magnitudes never reach ROUND, so input is nonzero.
                        r_unf    <= (w_field == '0);
                    end
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    if (bus.out_ready)
                        r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_float_normalize_round.sv
module tb_float_normalize_round;
    logic clk;
    logic res;
    int   cyc;
    int   errors;
    int   checks;

    float_normalize_round_if #(.EXP_W(8), .FRAC_W(23)) bus ();

    float_normalize_round #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          lat;
    } exp_t;

    exp_t q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int acc_cyc;
    bit lat_done;
    initial begin
        acc_cyc  = 0;
        lat_done = 1'b1;
        forever begin
            @(negedge clk);
            if (res && bus.in_valid && bus.in_ready) begin
                acc_cyc  = cyc;
                lat_done = 1'b0;
            end
            if (res && bus.out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h want none", bus.result);
                end else begin
                    if (!lat_done) begin
                        chk({q[0].name, ".latency"}, 32'(cyc - acc_cyc), 32'(q[0].lat));
                        lat_done = 1'b1;
                    end
                    if (!bus.out_ready) begin
                        chk({q[0].name, ".stall_result"}, bus.result, q[0].res);
                        chk({q[0].name, ".stall_in_ready"}, 32'(bus.in_ready), 32'd0);
                    end else begin
                        chk({q[0].name, ".result"},    bus.result,          q[0].res);
                        chk({q[0].name, ".overflow"},  32'(bus.overflow),   32'(q[0].ovf));
                        chk({q[0].name, ".underflow"}, 32'(bus.underflow),  32'(q[0].unf));
                        chk({q[0].name, ".inexact"},   32'(bus.inexact),    32'(q[0].inx));
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready) return;
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL in_ready_timeout: got 0 want 1");
    endtask

    task automatic send(input string nm, input logic [27:0] mant, input logic [7:0] ex,
                        input logic [31:0] r, input logic ovf, input logic unf,
                        input logic inx, input int lat, input int hold);
        exp_t e;
        bit   seen;
        e.name = nm; e.res = r; e.ovf = ovf; e.unf = unf; e.inx = inx; e.lat = lat;
        wait_ready();
        bus.out_ready = (hold == 0);
        q.push_back(e);
        bus.in_mant  = mant;
        bus.in_exp   = ex;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.out_valid) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s.out_valid_timeout: got 0 want 1", nm);
            q.delete();
            bus.out_ready = 1'b1;
            return;
        end
        repeat (hold) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!bus.out_valid) break;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        res = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mant   = '0;
        bus.in_exp    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.result",    bus.result,           32'h0);
        chk("reset.out_valid", 32'(bus.out_valid),   32'd0);
        chk("reset.in_ready",  32'(bus.in_ready),    32'd1);
        chk("reset.flags",     32'({bus.overflow, bus.underflow, bus.inexact}), 32'd0);
        res = 1'b1;
        @(posedge clk); #1;

        //    name          mant          exp    result        ovf unf inx lat hold
        send("one",        28'h2000000,  8'd127, 32'h3F800000, 0, 0, 0, 3,  0);
        send("carry",      28'h4000000,  8'd127, 32'h40000000, 0, 0, 0, 3,  0);
        send("norm2",      28'h0800000,  8'd130, 32'h40000000, 0, 0, 0, 5,  0);
        send("tie_up",     28'h2000006,  8'd127, 32'h3F800002, 0, 0, 1, 3,  0);
        send("tie_even",   28'h2000002,  8'd127, 32'h3F800000, 0, 0, 1, 3,  0);
        send("all_ones",   28'h3FFFFFE,  8'd127, 32'h40000000, 0, 0, 1, 3,  0);
        send("ovf_carry",  28'h4000000,  8'd254, 32'h7F800000, 1, 0, 0, 2,  0);
        send("denorm",     28'h0800000,  8'd1,   32'h00200000, 0, 1, 0, 4,  0);
        send("neg_zero",   28'h8000000,  8'd127, 32'h80000000, 0, 0, 0, 2,  0);
        send("neg_one",    28'hA000000,  8'd127, 32'hBF800000, 0, 0, 0, 3,  0);
        send("exp255",     28'h2000000,  8'd255, 32'h7F800000, 1, 0, 0, 1,  0);
        send("carry_stky", 28'h4000001,  8'd127, 32'h40000000, 0, 0, 1, 3,  0);
        send("exp0",       28'h2000000,  8'd0,   32'h00800000, 0, 0, 0, 3,  0);
        send("ovf_round",  28'h3FFFFFE,  8'd254, 32'h7F800000, 1, 0, 1, 3,  0);
        send("denorm_rnd", 28'h0000006,  8'd1,   32'h00000002, 0, 1, 1, 4,  0);
        send("norm23",     28'h0000004,  8'd127, 32'h34000000, 0, 0, 0, 26, 0);
        send("backpress",  28'h2000000,  8'd127, 32'h3F800000, 0, 0, 0, 3,  5);

        // Abort a long normalization with reset.
        wait_ready();
        bus.in_mant  = 28'h0000004;
        bus.in_exp   = 8'd127;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 res = 1'b0;
        #1;
        chk("abort.out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort.in_ready",  32'(bus.in_ready),  32'd1);
        chk("abort.result",    bus.result,         32'h0);
        @(posedge clk); #1;
        res = 1'b1;
        @(posedge clk); #1;
        send("post_reset", 28'h2000006, 8'd127, 32'h3F800002, 0, 0, 1, 3, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
